// File: rtl/dmem_dump_streamer_pkg.sv
// ----------------------------------------------------------------------------
// dmem_dump_streamer_pkg
// Shared types and constants for the data-memory dump streamer.
//   WORD_BYTES   : bytes per dmem word (address stride between beats)
//   word_t       : one 32-bit dmem word
//   dump_state_e : dump FSM states
// ----------------------------------------------------------------------------
package dmem_dump_streamer_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    DUMP_IDLE,
    DUMP_REQ,
    DUMP_RESP,
    DUMP_SEND,
    DUMP_FIN
  } dump_state_e;

endpackage

// File: rtl/dmem_dump_streamer_if.sv
// ----------------------------------------------------------------------------
// dmem_dump_streamer_if
// Bundles the dmem read port and the outgoing word stream of the dump
// streamer.
//   mem_rd_en / mem_rd_addr : read strobe and word-aligned byte address
//   mem_rd_data             : dmem data, valid one cycle after mem_rd_en
//   out_valid / out_ready   : stream handshake
//   out_data / out_last     : streamed word and end-of-dump marker
// master = streamer side, slave = memory + consumer side.
// ----------------------------------------------------------------------------
interface dmem_dump_streamer_if #(
  parameter int ADDR_W = 5
);
  import dmem_dump_streamer_pkg::*;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  word_t             mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  word_t             out_data;
  logic              out_last;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/dmem_dump_streamer.sv
// ----------------------------------------------------------------------------
// dmem_dump_streamer
// After the core halts, walks a window of dmem one word at a time and
// streams each word out on a valid/ready interface.
// Ports:
//   clk        : core clock, rising edge
//   reset      : asynchronous, active-high reset (aborts a dump, no done)
//   start      : one-cycle launch pulse, only honoured while idle
//   base_addr  : first byte address of the window (low two bits ignored)
//   len_words  : number of words to stream (0 = finish immediately)
//   busy       : high in every state except idle
//   done       : one-cycle pulse when the dump completes
//   bus        : dmem read port + output stream (master modport)
// ----------------------------------------------------------------------------
module dmem_dump_streamer
  import dmem_dump_streamer_pkg::*;
#(
  parameter int DMEM_SIZE_BYTES = 32,
  parameter int ADDR_W          = $clog2(DMEM_SIZE_BYTES),
  parameter int LEN_W           = ADDR_W - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    len_words,
  output logic                busy,
  output logic                done,
  dmem_dump_streamer_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [LEN_W-1:0]  REM_ONE    = LEN_W'(1);

  dump_state_e       r_state;
  dump_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;
  word_t             r_data;

  logic w_load;
  logic w_capture;
  logic w_xfer;
  logic w_rd_en;
  logic w_valid;
  logic w_done;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= DUMP_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    w_rd_en     = 1'b0;
    w_valid     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      DUMP_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (len_words == '0) ? DUMP_FIN : DUMP_REQ;
        end
      end
      DUMP_REQ: begin
        w_rd_en     = 1'b1;
        w_state_nxt = DUMP_RESP;
      end
      DUMP_RESP: begin
        w_capture   = 1'b1;
        w_state_nxt = DUMP_SEND;
      end
      DUMP_SEND: begin
        w_valid = 1'b1;
        if (bus.out_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = (r_rem == REM_ONE) ? DUMP_FIN : DUMP_REQ;
        end
      end
      DUMP_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = DUMP_IDLE;
      end
      default: w_state_nxt = DUMP_IDLE;
    endcase
  end

  // Address / remaining-count tracking; the address wraps naturally at the
  // top of dmem because it is exactly ADDR_W bits wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (w_load) begin
      r_addr <= base_addr & ALIGN_MASK;
      r_rem  <= len_words;
    end else if (w_xfer) begin
      r_addr <= r_addr + ADDR_STEP;
      r_rem  <= r_rem - REM_ONE;
    end
  end

  // Output word register: loaded only in RESP, so it stays frozen while the
  // consumer applies backpressure in SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_capture) begin
      r_data <= bus.mem_rd_data;
    end
  end

  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_addr = w_rd_en ? r_addr : '0;
  assign bus.out_valid   = w_valid;
  assign bus.out_data    = r_data;
  assign bus.out_last    = w_valid && (r_rem == REM_ONE);
  assign busy            = (r_state != DUMP_IDLE);
  assign done            = w_done;

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// ----------------------------------------------------------------------------
// tb_dmem_dump_streamer
// Bench for dmem_dump_streamer: a synchronous dmem model, a ready driver and
// a cycle-level reference model built from the dump rules (read one cycle
// after start or after the previous transfer, data two cycles after the
// read, done one cycle after the final transfer).
// ----------------------------------------------------------------------------
module tb_dmem_dump_streamer;
  import dmem_dump_streamer_pkg::*;

  localparam int DMEM_SIZE_BYTES = 32;
  localparam int ADDR_W          = $clog2(DMEM_SIZE_BYTES);
  localparam int LEN_W           = ADDR_W - 1;
  localparam int WORDS           = DMEM_SIZE_BYTES / WORD_BYTES;
  localparam int NEVER           = 32'h7fff_ffff;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len_words;
  logic              busy;
  logic              done;

  dmem_dump_streamer_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_dump_streamer #(
    .DMEM_SIZE_BYTES(DMEM_SIZE_BYTES),
    .ADDR_W         (ADDR_W),
    .LEN_W          (LEN_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .len_words(len_words),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  word_t mem [WORDS];

  // ready driver control
  int rdy_mode = 0;
  int stall_lo = NEVER;
  int stall_hi = NEVER;

  // reference model
  typedef struct {
    int    addr;
    word_t data;
    logic  last;
  } beat_t;
  beat_t m_q[$];
  int    m_idx       = 0;
  int    m_start_cyc = 0;
  int    m_done_cyc  = -1;
  int    m_rd_cyc    = NEVER;
  int    m_vld_from  = NEVER;

  // observations of the DUT for hand-computed checks
  word_t cap_data[$];
  int    cap_rdaddr[$];
  int    n_rd, n_vld, n_busy, n_done, n_last, n_rd_stall;
  int    first_vld_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc, last_beat_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_cap();
    cap_data.delete();
    cap_rdaddr.delete();
    n_rd = 0; n_vld = 0; n_busy = 0; n_done = 0; n_last = 0; n_rd_stall = 0;
    first_vld_cyc = -1; first_xfer_cyc = -1; last_xfer_cyc = -1;
    done_cyc = -1; last_beat_idx = -1;
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // synchronous dmem read port
  initial begin
    bus.mem_rd_data = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr[ADDR_W-1:2]];
    end
  end

  // consumer ready
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = ($urandom % 4) != 0;
        2:       bus.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
        3:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // per-cycle compare against the model, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_busy",   busy, 0);
      chk("rst_done",   done, 0);
      chk("rst_rd_en",  bus.mem_rd_en, 0);
      chk("rst_rd_addr", bus.mem_rd_addr, 0);
      chk("rst_valid",  bus.out_valid, 0);
      chk("rst_data",   bus.out_data, 0);
      chk("rst_last",   bus.out_last, 0);
      m_q.delete();
      m_idx      = 0;
      m_done_cyc = -1;
      m_rd_cyc   = NEVER;
      m_vld_from = NEVER;
    end else begin
      logic exp_rd, exp_vld, exp_busy, exp_done;
      exp_rd   = (cyc == m_rd_cyc);
      exp_vld  = (m_vld_from <= cyc) && (m_idx < m_q.size());
      exp_busy = (cyc > m_start_cyc) && (cyc <= m_done_cyc);
      exp_done = (cyc == m_done_cyc);
      chk("rd_en", bus.mem_rd_en, exp_rd);
      chk("valid", bus.out_valid, exp_vld);
      chk("busy",  busy, exp_busy);
      chk("done",  done, exp_done);
      if (exp_rd && m_idx < m_q.size()) chk("rd_addr", bus.mem_rd_addr, m_q[m_idx].addr);
      if (exp_vld) begin
        chk("data", bus.out_data, m_q[m_idx].data);
        chk("last", bus.out_last, m_q[m_idx].last);
      end

      if (bus.mem_rd_en) begin
        n_rd++;
        cap_rdaddr.push_back(int'(bus.mem_rd_addr));
        if (cyc >= stall_lo && cyc < stall_hi) n_rd_stall++;
      end
      if (bus.out_valid) begin
        n_vld++;
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bus.out_ready) begin
          cap_data.push_back(bus.out_data);
          if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
          last_xfer_cyc = cyc;
          if (bus.out_last) begin
            n_last++;
            last_beat_idx = cap_data.size() - 1;
          end
        end
      end
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end

      // advance the model
      if (exp_rd) begin
        m_vld_from = cyc + 2;
        m_rd_cyc   = NEVER;
      end
      if (exp_vld && bus.out_ready) begin
        if (m_idx == m_q.size() - 1) m_done_cyc = cyc + 1;
        else                          m_rd_cyc   = cyc + 1;
        m_idx++;
        m_vld_from = NEVER;
      end
      if (start && cyc > m_done_cyc) begin
        int b0;
        m_start_cyc = cyc;
        m_q.delete();
        m_idx = 0;
        b0 = (int'(base_addr) / WORD_BYTES) * WORD_BYTES;
        for (int i = 0; i < int'(len_words); i++) begin
          beat_t bt;
          bt.addr = (b0 + WORD_BYTES * i) % DMEM_SIZE_BYTES;
          bt.data = mem[bt.addr / WORD_BYTES];
          bt.last = (i == int'(len_words) - 1);
          m_q.push_back(bt);
        end
        if (len_words == '0) begin
          m_done_cyc = cyc + 1;
        end else begin
          m_done_cyc = NEVER;
          m_rd_cyc   = cyc + 1;
        end
      end
    end
  end

  task automatic do_start(input int b, input int l);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    len_words = LEN_W'(l);
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (cyc <= m_done_cyc) begin
      @(posedge clk);
      #1;
      n++;
      if (n > budget) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wait_idle: dump still running after %0d cycles", budget);
        break;
      end
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < WORDS; k++) mem[k] = 32'hA000_0000 + k;
  endtask

  // global time limit
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len_words = '0;
    load_ramp();
    clear_cap();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_busy",  busy, 0);
    chk("post_rst_valid", bus.out_valid, 0);
    chk("post_rst_rd_en", bus.mem_rd_en, 0);

    // basic 8-word dump
    clear_cap();
    s = cyc + 1;
    do_start(0, 8);
    wait_idle(200);
    chk("t1_beats",      cap_data.size(), 8);
    chk("t1_word0",      cap_data[0], 32'hA000_0000);
    chk("t1_word7",      cap_data[7], 32'hA000_0007);
    chk("t1_first_vld",  first_vld_cyc - s, 3);
    chk("t1_first_rd",   n_rd, 8);
    chk("t1_throughput", last_xfer_cyc - first_xfer_cyc, 21);
    chk("t1_last_cnt",   n_last, 1);
    chk("t1_last_idx",   last_beat_idx, 7);
    chk("t1_done_lat",   done_cyc - last_xfer_cyc, 1);

    // wrap past the top of dmem
    clear_cap();
    do_start(32'h1C, 3);
    wait_idle(200);
    chk("t2_addr0", cap_rdaddr[0], 32'h1C);
    chk("t2_addr1", cap_rdaddr[1], 32'h00);
    chk("t2_addr2", cap_rdaddr[2], 32'h04);
    chk("t2_data0", cap_data[0], 32'hA000_0007);
    chk("t2_data1", cap_data[1], 32'hA000_0000);
    chk("t2_data2", cap_data[2], 32'hA000_0001);

    // backpressure for 5 cycles on beat 2
    clear_cap();
    s        = cyc + 1;
    stall_lo = s + 6;
    stall_hi = s + 11;
    rdy_mode = 2;
    do_start(0, 4);
    wait_idle(200);
    chk("t3_beats",    cap_data.size(), 4);
    chk("t3_beat1",    cap_data[1], 32'hA000_0001);
    chk("t3_vld_cyc",  n_vld, 9);
    chk("t3_rd_cnt",   n_rd, 4);
    chk("t3_rd_stall", n_rd_stall, 0);
    chk("t3_done_cyc", done_cyc - s, 18);
    rdy_mode = 0;
    stall_lo = NEVER;
    stall_hi = NEVER;

    // zero-length dump
    clear_cap();
    do_start(8, 0);
    wait_idle(50);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_rd",   n_rd, 0);
    chk("t4_vld",  n_vld, 0);
    chk("t4_busy", n_busy, 1);
    chk("t4_done", n_done, 1);

    // second start while busy is ignored
    clear_cap();
    do_start(0, 3);
    do_start(32'h10, 5);
    wait_idle(200);
    chk("t5_beats", cap_data.size(), 3);
    chk("t5_word2", cap_data[2], 32'hA000_0002);
    chk("t5_done",  n_done, 1);

    // reset during SEND of beat 3
    s = cyc + 1;
    do_start(0, 6);
    while (cyc < s + 9) begin
      @(posedge clk);
      #1;
    end
    chk("t6_pre_valid", bus.out_valid, 1);
    #1;
    clear_cap();
    reset = 1'b1;
    #1;
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_busy",  busy, 0);
    chk("t6_data",  bus.out_data, 0);
    chk("t6_done",  done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_done", n_done, 0);
    chk("t6_no_busy", n_busy, 0);
    clear_cap();
    do_start(0, 2);
    wait_idle(100);
    chk("t6_beats", cap_data.size(), 2);
    chk("t6_word0", cap_data[0], 32'hA000_0000);
    chk("t6_word1", cap_data[1], 32'hA000_0001);

    // randomized dumps with random backpressure and stray starts
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      int b, l;
      for (int k = 0; k < WORDS; k++) mem[k] = $urandom;
      b = $urandom % DMEM_SIZE_BYTES;
      l = $urandom % (1 << LEN_W);
      do_start(b, l);
      if (l >= 1 && ($urandom % 2) == 1) do_start($urandom % DMEM_SIZE_BYTES, $urandom % (1 << LEN_W));
      wait_idle(400);
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
